data_cache_controller: RTL

Direct-mapped, write-through, no-write-allocate data cache between the MIPS datapath load/store port and `dataMemoryModule`. It serves 32-bit word accesses from 16 cached 128-bit lines. On a read miss it drives a line-aligned address to the memory and holds it for a fixed refill window before capturing the memory's 128-bit `data` output. Stores are forwarded to memory as single-cycle `writeMem` pulses, and a store that hits also updates the cached word.

---
 rtl/dcache_pkg.sv | 36 +++
 rtl/dcache_line_store.sv | 65 ++++++
 rtl/data_cache_controller.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_pkg
// Description : Shared types, widths and address-field helpers for the
//               direct-mapped write-through data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  localparam int WORD_W = 32;
  localparam int LINE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Word within the 16-byte line.
  function automatic logic [1:0] addr_word(input logic [31:0] addr);
    return addr[3:2];
  endfunction

  // Line index, right-aligned; caller keeps the low index_w bits.
  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
    return (addr >> 4) & ((32'd1 << index_w) - 32'd1);
  endfunction

  // Tag, right-aligned; caller keeps the low (28 - index_w) bits.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
    return addr >> (4 + index_w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_line_store.sv
`default_nettype none
// ============================================================================
// Module      : dcache_line_store
// Description : Valid/tag/data arrays for the direct-mapped data cache.
//               One combinational lookup port, one whole-line fill port and
//               one single-word update port. Only the valid bits are reset.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               rd_index/tag/word  - lookup address fields
//               rd_hit, rd_data    - lookup result (combinational)
//               fill_*             - install a full line, sets valid
//               upd_*              - overwrite one word of a resident line
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES   = 16,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [TAG_W-1:0]    rd_tag,
  input  logic [1:0]          rd_word,
  output logic                rd_hit,
  output logic [WORD_W-1:0]   rd_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_data,
  input  logic                upd_en,
  input  logic [INDEX_W-1:0]  upd_index,
  input  logic [1:0]          upd_word,
  input  logic [WORD_W-1:0]   upd_data
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [LINE_W-1:0] lines [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  // Fill and update never coincide (fill happens in REFILL, update in IDLE);
  // fill is given priority anyway.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[fill_index]  <= fill_tag;
      lines[fill_index] <= fill_data;
    end else if (upd_en) begin
      lines[upd_index][{upd_word, 5'b00000} +: WORD_W] <= upd_data;
    end
  end

  assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
  assign rd_data = lines[rd_index][{rd_word, 5'b00000} +: WORD_W];

endmodule
`default_nettype wire

// File: rtl/data_cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_controller
// Description : Direct-mapped, write-through, no-write-allocate data cache
//               between the CPU load/store port and a 128-bit-line memory.
//               Read misses hold a line-aligned address for REFILL_CYCLES
//               cycles, then capture memData; stores always go to memory as
//               a one-cycle memWrite pulse and update the line on a hit.
// Ports       : CLk, reset                  - clock, sync active-high reset
//               cpuAddress/WriteData        - CPU request address and data
//               cpuRead, cpuWrite           - held until ready
//               cpuReadData, ready          - load result, completion pulse
//               memAddress/WriteData/Write  - memory request
//               memData                     - memory line output
//               hitCount, missCount         - wrapping load statistics
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_controller
  import dcache_pkg::*;
#(
  parameter int LINES         = 16,
  parameter int REFILL_CYCLES = 5
) (
  input  logic                CLk,
  input  logic                reset,
  input  logic [31:0]         cpuAddress,
  input  logic [31:0]         cpuWriteData,
  input  logic                cpuRead,
  input  logic                cpuWrite,
  output logic [31:0]         cpuReadData,
  output logic                ready,
  output logic [31:0]         memAddress,
  output logic [31:0]         memWriteData,
  output logic                memWrite,
  input  logic [LINE_W-1:0]   memData,
  output logic [31:0]         hitCount,
  output logic [31:0]         missCount
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = 28 - INDEX_W;
  localparam int CNT_W   = (REFILL_CYCLES > 1) ? $clog2(REFILL_CYCLES) : 1;

  state_t state, next_state;
  logic [CNT_W-1:0] refill_cnt;
  logic             refill_done;

  logic [31:0]        cpu_index_full, cpu_tag_full, fill_index_full, fill_tag_full;
  logic [INDEX_W-1:0] cpu_index, fill_index;
  logic [TAG_W-1:0]   cpu_tag, fill_tag;
  logic [1:0]         cpu_word;
  logic               cpu_hit;
  logic [WORD_W-1:0]  cpu_word_data;
  logic               fill_en, upd_en;

  // CPU-side lookup uses the live request; the fill uses the held refill
  // address, which is exactly memAddress during REFILL.
  assign cpu_index_full  = addr_index(cpuAddress, INDEX_W);
  assign cpu_tag_full    = addr_tag(cpuAddress, INDEX_W);
  assign cpu_word        = addr_word(cpuAddress);
  assign fill_index_full = addr_index(memAddress, INDEX_W);
  assign fill_tag_full   = addr_tag(memAddress, INDEX_W);
  assign cpu_index       = cpu_index_full[INDEX_W-1:0];
  assign cpu_tag         = cpu_tag_full[TAG_W-1:0];
  assign fill_index      = fill_index_full[INDEX_W-1:0];
  assign fill_tag        = fill_tag_full[TAG_W-1:0];

  logic unused_bits;
  assign unused_bits = ^{cpuAddress[1:0], cpu_index_full[31:INDEX_W], cpu_tag_full[31:TAG_W],
                         fill_index_full[31:INDEX_W], fill_tag_full[31:TAG_W]};

  assign refill_done = (refill_cnt == CNT_W'(REFILL_CYCLES - 1));
  // A reset landing on the final refill edge must not install the line.
  assign fill_en     = (state == ST_REFILL) && refill_done && !reset;
  assign upd_en      = (state == ST_IDLE) && cpuWrite && cpu_hit;

  dcache_line_store #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_store (
    .clk        (CLk),
    .reset      (reset),
    .rd_index   (cpu_index),
    .rd_tag     (cpu_tag),
    .rd_word    (cpu_word),
    .rd_hit     (cpu_hit),
    .rd_data    (cpu_word_data),
    .fill_en    (fill_en),
    .fill_index (fill_index),
    .fill_tag   (fill_tag),
    .fill_data  (memData),
    .upd_en     (upd_en),
    .upd_index  (cpu_index),
    .upd_word   (cpu_word),
    .upd_data   (cpuWriteData)
  );

  // State register
  always_ff @(posedge CLk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a store wins over a simultaneous load.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (cpuWrite) begin
          next_state = ST_WRITE;
        end else if (cpuRead) begin
          next_state = cpu_hit ? ST_RESP : ST_REFILL;
        end
      end
      ST_REFILL: begin
        // Back to IDLE: the still-held load then completes as a hit.
        if (refill_done) begin
          next_state = ST_IDLE;
        end
      end
      ST_WRITE: next_state = ST_RESP;
      ST_RESP:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded directly from the state register
  always_comb begin
    memWrite = 1'b0;
    ready    = 1'b0;
    case (state)
      ST_WRITE: memWrite = 1'b1;
      ST_RESP:  ready    = 1'b1;
      default: begin
        memWrite = 1'b0;
        ready    = 1'b0;
      end
    endcase
  end

  // Registered outputs and refill counter
  always_ff @(posedge CLk) begin
    if (reset) begin
      memAddress   <= '0;
      memWriteData <= '0;
      cpuReadData  <= '0;
      hitCount     <= '0;
      missCount    <= '0;
      refill_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpuWrite) begin
            memAddress   <= {cpuAddress[31:2], 2'b00};
            memWriteData <= cpuWriteData;
          end else if (cpuRead) begin
            if (cpu_hit) begin
              cpuReadData <= cpu_word_data;
              hitCount    <= hitCount + 32'd1;
            end else begin
              memAddress <= {cpuAddress[31:4], 4'b0000};
              refill_cnt <= '0;
              missCount  <= missCount + 32'd1;
            end
          end
        end
        ST_REFILL: refill_cnt <= refill_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
